soc_ram_mp: RTL and testbench
=============================

Name: soc_ram_mp

Overview:
- Parametrised multi-port memory: NPORTS requesters share one single-port word array through a round-robin arbiter.
- Per-port byte-lane write enables and a configurable pipelined read latency.
- Per-port wait and read-valid handshakes.
- Successor to the single-port data/program RAM wrappers: lets CPU, DMA and debug masters share one DMEM/PMEM bank without external muxing.

Parameters:
- ADDR_MSB, 6: MSB of the per-port word address.
- MEM_SIZE, 256: memory size in bytes.
- DATA_WIDTH, 16: word width; a multiple of 8. NBYTES = DATA_WIDTH/8.
- NPORTS, 2: number of requesters, 1..8.
- READ_LATENCY, 1: read data latency, 1 or 2 cycles.

Ports:
- ram_clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_cen  in  NPORTS  per-port chip enable, active low; 0 = request.
- port_wen  in  NPORTS*NBYTES  per-port byte write enables, active low; all ones = read.
- port_addr  in  NPORTS*(ADDR_MSB+1)  per-port word address.
- port_din  in  NPORTS*DATA_WIDTH  per-port write data.
- port_dout  out  NPORTS*DATA_WIDTH  per-port read data.
- port_wait  out  NPORTS  1 = request present but not granted this cycle.
- port_rvalid  out  NPORTS  one-cycle pulse: port_dout carries fresh read data.

Behaviour:
- Reset, asynchronous: port_dout=0, port_rvalid=0, arbiter pointer=0, read pipeline cleared. Array contents are not cleared.
- Request: req[i] = ~port_cen[i].
- Grant: combinational, one-hot, at most one port per cycle. Search starts at the pointer and ascends modulo NPORTS; the first requester wins.
- port_wait[i] = req[i] & ~grant[i]. A waiting port holds cen/wen/addr/din stable until wait is low. A dropped request is lost, with no side effect.
- Pointer: on any grant to port g, the pointer becomes (g+1) mod NPORTS at the clock edge. No grant leaves the pointer unchanged.
- Write (any wen lane low) on the grant edge:
  - Only lanes with wen bit 0 are updated.
  - No port_rvalid.
  - The write completes in the grant cycle.
- Read (wen all ones) on the grant edge: the array is read.
  - READ_LATENCY=1: port_dout[g] and port_rvalid[g]=1 in the cycle after the grant.
  - READ_LATENCY=2: an output register adds one cycle.
  - Reads are pipelined: back-to-back grants yield back-to-back rvalid pulses in grant order.
- port_dout[i] holds its last value until the next read for port i. Other ports' dout are unaffected.
- Range: the valid word range is 0..MEM_SIZE/NBYTES-1.
  - Out-of-range write: ignored.
  - Out-of-range read: returns 0 with rvalid=1.
- Mixed lanes: a partial-write access does not return data.
- Single requester: never waits; full throughput, one access per cycle.
- Reset asserted mid-read: the pending rvalid is discarded. After release the first grant goes to the lowest-index requester.

Decomposition:
- Package soc_ram_mp_pkg:
  - functions nbytes(width) and words(size,width);
  - localparam bounds MAX_PORTS=8 and READ_LATENCY range checks, both as elaboration asserts.
- Sub-module soc_ram_rr_arb (NPORTS): inputs req; outputs grant one-hot and grant index; owns the pointer register and async reset.
- Top level owns:
  - the array, inferred single-port with byte enables;
  - the read pipeline carrying grant index, valid and in-range flag;
  - per-port output registers.

Test Plan:
- Reset with NPORTS=2, DATA_WIDTH=16: assert reset_n=0 mid-stream -> all port_dout=0, port_rvalid=0, port_wait=0 while held.
- Port0 writes 0xBEEF at word 3 (wen=00), then reads word 3 -> port_rvalid[0]=1 exactly 1 cycle after the read grant (2 with READ_LATENCY=2), port_dout[0]=0xBEEF.
- Byte lanes: word 5 = 0x1234, then port1 writes din=0xAB00 with wen=01 -> reading word 5 gives 0xAB34.
- Contention: both ports request reads every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; each port_wait high on alternate cycles; 3 rvalid pulses per port.
- Out of range (MEM_SIZE=256, 128 words): port0 writes 0x5555 to word 200 (with ADDR_MSB=7), then reads word 200 -> port_dout[0]=0 with rvalid=1; word 200 mod 128=72 is unchanged.
- Reset mid-operation: reset asserted the cycle after a read grant -> no rvalid after release; the pointer restarts, so port0 wins the first contended grant.

Source files
------------

// File: rtl/soc_ram_mp_pkg.sv
// Shared sizing helpers and parameter bounds for the multi-port RAM.
package soc_ram_mp_pkg;

  localparam int unsigned MAX_PORTS        = 8;
  localparam int unsigned MIN_READ_LATENCY = 1;
  localparam int unsigned MAX_READ_LATENCY = 2;

  // Bytes per word.
  function automatic int unsigned nbytes(input int unsigned width);
    return width / 8;
  endfunction

  // Words held by a byte-sized memory.
  function automatic int unsigned words(input int unsigned size, input int unsigned width);
    return size / nbytes(width);
  endfunction

endpackage

// File: rtl/soc_ram_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module soc_ram_rr_arb #(
  parameter int unsigned NPORTS = 2,
  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] grant_c,
  output logic [IDX_W-1:0]  grant_idx_c,
  output logic              grant_vld_c
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand_c;

  // First requester at or after the pointer, wrapping modulo NPORTS.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    cand_c      = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand_c = IDX_W'((32'(ptr_q) + 32'(k)) % NPORTS);
      if (!grant_vld_c && req[cand_c]) begin
        grant_vld_c     = 1'b1;
        grant_c[cand_c] = 1'b1;
        grant_idx_c     = cand_c;
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (grant_vld_c) begin
      ptr_q <= (32'(grant_idx_c) == NPORTS - 1) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/soc_ram_mp.sv
// Multi-port RAM: NPORTS requesters share one byte-enabled word array.
module soc_ram_mp
  import soc_ram_mp_pkg::*;
#(
  parameter int unsigned ADDR_MSB     = 6,
  parameter int unsigned MEM_SIZE     = 256,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NPORTS       = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                                   ram_clk,
  input  logic                                   reset_n,
  input  logic [NPORTS-1:0]                      port_cen,
  input  logic [NPORTS*(DATA_WIDTH/8)-1:0]       port_wen,
  input  logic [NPORTS*(ADDR_MSB+1)-1:0]         port_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]           port_din,
  output logic [NPORTS*DATA_WIDTH-1:0]           port_dout,
  output logic [NPORTS-1:0]                      port_wait,
  output logic [NPORTS-1:0]                      port_rvalid
);

  localparam int unsigned NB     = nbytes(DATA_WIDTH);
  localparam int unsigned AW     = ADDR_MSB + 1;
  localparam int unsigned NWORDS = words(MEM_SIZE, DATA_WIDTH);
  localparam int unsigned MW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Elaboration-time parameter sanity.
  if (NPORTS < 1 || NPORTS > MAX_PORTS) begin : g_bad_nports
    $error("soc_ram_mp: NPORTS out of range");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("soc_ram_mp: READ_LATENCY must be 1 or 2");
  end

  logic [NPORTS-1:0]     req_c;
  logic [NPORTS-1:0]     grant_c;
  logic [IDX_W-1:0]      gidx_c;
  logic                  gvld_c;

  logic [NB-1:0]         g_wen_c;
  logic [AW-1:0]         g_addr_c;
  logic [DATA_WIDTH-1:0] g_din_c;
  logic [MW-1:0]         g_row_c;
  logic                  g_inr_c;
  logic                  g_rd_c;
  logic                  g_wr_c;

  logic [DATA_WIDTH-1:0] mem [NWORDS];

  logic                  fin_vld;
  logic [IDX_W-1:0]      fin_idx;
  logic                  fin_inr;
  logic [DATA_WIDTH-1:0] fin_data;

  logic [DATA_WIDTH-1:0] dout_q [NPORTS];
  logic [NPORTS-1:0]     rvalid_q;

  // Requests are masked in reset so nothing is granted or shown waiting.
  assign req_c     = ~port_cen & {NPORTS{reset_n}};
  assign port_wait = req_c & ~grant_c;

  soc_ram_rr_arb #(.NPORTS(NPORTS)) u_arb (
    .clk         (ram_clk),
    .rst_n       (reset_n),
    .req         (req_c),
    .grant_c     (grant_c),
    .grant_idx_c (gidx_c),
    .grant_vld_c (gvld_c)
  );

  // Steer the winning port's request fields onto the shared array port.
  always_comb begin
    g_wen_c  = '1;
    g_addr_c = '0;
    g_din_c  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (grant_c[p]) begin
        g_wen_c  = port_wen[p*NB +: NB];
        g_addr_c = port_addr[p*AW +: AW];
        g_din_c  = port_din[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign g_inr_c = (32'(g_addr_c) < NWORDS);
  assign g_row_c = MW'(g_addr_c);
  assign g_rd_c  = gvld_c & (g_wen_c == '1);
  assign g_wr_c  = gvld_c & (g_wen_c != '1) & g_inr_c;

  // Byte-lane writes; out-of-range addresses never touch the array.
  always_ff @(posedge ram_clk) begin
    if (g_wr_c) begin
      for (int b = 0; b < NB; b++) begin
        if (!g_wen_c[b]) mem[g_row_c][b*8 +: 8] <= g_din_c[b*8 +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_vld;
    logic [IDX_W-1:0]      s1_idx;
    logic                  s1_inr;
    logic [DATA_WIDTH-1:0] s1_data;

    // Extra read stage carrying the destination port and range flag.
    always_ff @(posedge ram_clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_vld  <= 1'b0;
        s1_idx  <= '0;
        s1_inr  <= 1'b0;
        s1_data <= '0;
      end else begin
        s1_vld  <= g_rd_c;
        s1_idx  <= gidx_c;
        s1_inr  <= g_inr_c;
        s1_data <= mem[g_row_c];
      end
    end

    assign fin_vld  = s1_vld;
    assign fin_idx  = s1_idx;
    assign fin_inr  = s1_inr;
    assign fin_data = s1_data;
  end else begin : g_lat1
    assign fin_vld  = g_rd_c;
    assign fin_idx  = gidx_c;
    assign fin_inr  = g_inr_c;
    assign fin_data = mem[g_row_c];
  end

  // Per-port output registers: only the addressed port's data changes.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPORTS; p++) dout_q[p] <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (fin_vld) begin
        rvalid_q[fin_idx] <= 1'b1;
        dout_q[fin_idx]   <= fin_inr ? fin_data : '0;
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_dout
    assign port_dout[p*DATA_WIDTH +: DATA_WIDTH] = dout_q[p];
  end

  assign port_rvalid = rvalid_q;

endmodule

// File: tb/tb_soc_ram_mp.sv
// Directed bench for soc_ram_mp: 2 ports, 16-bit words, 8-bit address, 2-cycle reads.
module tb_soc_ram_mp;

  localparam int unsigned RL = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cen;
  logic [3:0]  wen;
  logic [15:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [1:0]  pwait;
  logic [1:0]  rvalid;

  int errors;
  int checks;

  soc_ram_mp #(
    .ADDR_MSB     (7),
    .MEM_SIZE     (256),
    .DATA_WIDTH   (16),
    .NPORTS       (2),
    .READ_LATENCY (RL)
  ) dut (
    .ram_clk     (clk),
    .reset_n     (rst_n),
    .port_cen    (cen),
    .port_wen    (wen),
    .port_addr   (addr),
    .port_din    (din),
    .port_dout   (dout),
    .port_wait   (pwait),
    .port_rvalid (rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic c, input logic [1:0] w,
                          input logic [7:0] a, input logic [15:0] d);
    cen[p]          = c;
    wen[p*2 +: 2]   = w;
    addr[p*8 +: 8]  = a;
    din[p*16 +: 16] = d;
  endtask

  task automatic idle();
    cen = 2'b11;
    wen = 4'hF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cen   = 2'b00;
    wen   = 4'hF;
    repeat (3) tick();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want %h", dout, 32'h0); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (pwait !== 2'b00) begin errors++; $display("FAIL reset_wait: got %b want 00", pwait); end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int lat;
    set_port(0, 1'b0, 2'b00, 8'd3, 16'hBEEF);
    #1;
    checks++; if (pwait !== 2'b00) begin errors++; $display("FAIL wr_wait: got %b want 00", pwait); end
    tick();
    set_port(0, 1'b0, 2'b11, 8'd3, 16'h0);
    tick();
    idle();
    lat = 1;
    while (!rvalid[0] && lat < 6) begin tick(); lat++; end
    checks++; if (lat !== RL) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, RL); end
    checks++; if (dout[15:0] !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want BEEF", dout[15:0]); end
    checks++; if (dout[31:16] !== 16'h0) begin errors++; $display("FAIL rd_other_port: got %h want 0000", dout[31:16]); end
    tick();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rd_pulse_end: got %b want 00", rvalid); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    set_port(0, 1'b0, 2'b00, 8'd5, 16'h1234);
    tick();
    idle();
    set_port(1, 1'b0, 2'b01, 8'd5, 16'hAB00);
    #1;
    checks++; if (pwait !== 2'b00) begin errors++; $display("FAIL bl_wait: got %b want 00", pwait); end
    tick();
    idle();
    set_port(1, 1'b0, 2'b11, 8'd5, 16'h0);
    tick();
    idle();
    lat = 1;
    while (!rvalid[1] && lat < 6) begin tick(); lat++; end
    checks++; if (lat !== RL) begin errors++; $display("FAIL bl_latency: got %0d want %0d", lat, RL); end
    checks++; if (dout[31:16] !== 16'hAB34) begin errors++; $display("FAIL bl_data: got %h want AB34", dout[31:16]); end
    checks++; if (dout[15:0] !== 16'hBEEF) begin errors++; $display("FAIL bl_port0_hold: got %h want BEEF", dout[15:0]); end
    tick();
  endtask

  task automatic test_contention();
    int cnt0, cnt1;
    logic [1:0] exp_wait;
    cnt0 = 0;
    cnt1 = 0;
    set_port(0, 1'b0, 2'b11, 8'd3, 16'h0);
    set_port(1, 1'b0, 2'b11, 8'd5, 16'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_wait = (k % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (pwait !== exp_wait) begin errors++; $display("FAIL ct_wait[%0d]: got %b want %b", k, pwait, exp_wait); end
      tick();
      cnt0 += int'(rvalid[0]);
      cnt1 += int'(rvalid[1]);
    end
    idle();
    repeat (3) begin
      tick();
      cnt0 += int'(rvalid[0]);
      cnt1 += int'(rvalid[1]);
    end
    checks++; if (cnt0 !== 3) begin errors++; $display("FAIL ct_pulses0: got %0d want 3", cnt0); end
    checks++; if (cnt1 !== 3) begin errors++; $display("FAIL ct_pulses1: got %0d want 3", cnt1); end
    checks++; if (dout !== 32'hAB34_BEEF) begin errors++; $display("FAIL ct_data: got %h want AB34BEEF", dout); end
  endtask

  task automatic test_out_of_range();
    int lat;
    set_port(0, 1'b0, 2'b00, 8'd72, 16'h7272);
    tick();
    set_port(0, 1'b0, 2'b00, 8'd200, 16'h5555);
    tick();
    set_port(0, 1'b0, 2'b11, 8'd200, 16'h0);
    tick();
    idle();
    lat = 1;
    while (!rvalid[0] && lat < 6) begin tick(); lat++; end
    checks++; if (lat !== RL) begin errors++; $display("FAIL oor_latency: got %0d want %0d", lat, RL); end
    checks++; if (dout[15:0] !== 16'h0) begin errors++; $display("FAIL oor_data: got %h want 0000", dout[15:0]); end
    tick();
    set_port(0, 1'b0, 2'b11, 8'd72, 16'h0);
    tick();
    idle();
    lat = 1;
    while (!rvalid[0] && lat < 6) begin tick(); lat++; end
    checks++; if (dout[15:0] !== 16'h7272) begin errors++; $display("FAIL oor_alias: got %h want 7272", dout[15:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  rd_addr [3];
    logic [15:0] exp_val [3];
    logic [15:0] got [8];
    int          pos [8];
    int          n;
    int          step;
    rd_addr[0] = 8'd3;  exp_val[0] = 16'hBEEF;
    rd_addr[1] = 8'd5;  exp_val[1] = 16'hAB34;
    rd_addr[2] = 8'd72; exp_val[2] = 16'h7272;
    n = 0;
    step = 0;
    for (int i = 0; i < 3; i++) begin
      set_port(1, 1'b0, 2'b11, rd_addr[i], 16'h0);
      #1;
      checks++; if (pwait !== 2'b00) begin errors++; $display("FAIL b2b_wait[%0d]: got %b want 00", i, pwait); end
      tick();
      step++;
      if (rvalid[1] && n < 8) begin got[n] = dout[31:16]; pos[n] = step; n++; end
    end
    idle();
    repeat (4) begin
      tick();
      step++;
      if (rvalid[1] && n < 8) begin got[n] = dout[31:16]; pos[n] = step; n++; end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    if (n >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== exp_val[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], exp_val[i]); end
      end
      checks++; if (pos[2] - pos[0] !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d want 2", pos[2] - pos[0]); end
    end
    checks++; if (dout[15:0] !== 16'h7272) begin errors++; $display("FAIL b2b_port0_hold: got %h want 7272", dout[15:0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] seen;
    int cnt0;
    set_port(0, 1'b0, 2'b11, 8'd3, 16'h0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rm_rvalid: got %b want 00", rvalid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rm_dout: got %h want 0", dout); end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 2'b00;
    repeat (3) begin
      tick();
      seen |= rvalid;
    end
    checks++; if (seen !== 2'b00) begin errors++; $display("FAIL rm_no_rvalid: got %b want 00", seen); end
    set_port(0, 1'b0, 2'b11, 8'd5, 16'h0);
    set_port(1, 1'b0, 2'b11, 8'd3, 16'h0);
    #1;
    checks++; if (pwait !== 2'b10) begin errors++; $display("FAIL rm_first_grant: got %b want 10", pwait); end
    tick();
    idle();
    cnt0 = 0;
    seen = 2'b00;
    repeat (4) begin
      tick();
      cnt0 += int'(rvalid[0]);
      seen |= rvalid;
    end
    checks++; if (cnt0 !== 1) begin errors++; $display("FAIL rm_pulse0: got %0d want 1", cnt0); end
    checks++; if (seen[1] !== 1'b0) begin errors++; $display("FAIL rm_dropped1: got %b want 0", seen[1]); end
    checks++; if (dout !== 32'h0000_AB34) begin errors++; $display("FAIL rm_data: got %h want 0000AB34", dout); end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    cen    = 2'b11;
    wen    = 4'hF;
    addr   = '0;
    din    = '0;
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_contention();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
